// File: rtl/stage_sequencer.sv
// stage_sequencer
//   Opcode-aware multi-cycle sequencer for the MUSA core. Walks each
//   instruction through IF/ID/EX/MEM/WB, skipping the stages its opcode
//   does not need. IF and MEM wait on a memory ready handshake. The block
//   also handles halt/resume and a sticky memory-timeout / illegal-opcode
//   fault.
//
// Parameters
//   WAIT_MAX     consecutive IF/MEM wait cycles before FAULT (0 = no timeout)
//   RET_W        width of the retired-instruction counter
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset; forces every output to 0
//   i_opcode     instruction opcode, sampled in ID only
//   i_mem_ready  acknowledge for the current instruction or data request
//   i_resume     leave HALT
//   o_stage      IF=000 ID=001 EX=010 MEM=011 WB=100 HALT=101 FAULT=110
//   o_inst_req   instruction fetch request (every IF cycle)
//   o_ir_load    instruction register load (IF & mem_ready)
//   o_data_req   data memory request (every MEM cycle)
//   o_data_we    data write (MEM of a sw)
//   o_rf_we      register-file write (WB)
//   o_write_pc   one-cycle PC update strobe, last cycle of each path
//   o_halted     high in HALT
//   o_fault      high in FAULT, sticky until reset
//   o_retired    completed-instruction count, wraps
module stage_sequencer #(
    parameter int WAIT_MAX = 15,
    parameter int RET_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [5:0]       i_opcode,
    input  logic             i_mem_ready,
    input  logic             i_resume,
    output logic [2:0]       o_stage,
    output logic             o_inst_req,
    output logic             o_ir_load,
    output logic             o_data_req,
    output logic             o_data_we,
    output logic             o_rf_we,
    output logic             o_write_pc,
    output logic             o_halted,
    output logic             o_fault,
    output logic [RET_W-1:0] o_retired
);

    localparam int WW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam int WAIT_LAST_I = (WAIT_MAX > 0) ? WAIT_MAX - 1 : 0;
    localparam logic [WW-1:0] WAIT_LAST = WAIT_LAST_I[WW-1:0];

    localparam logic [2:0] S_IF    = 3'b000;
    localparam logic [2:0] S_ID    = 3'b001;
    localparam logic [2:0] S_EX    = 3'b010;
    localparam logic [2:0] S_MEM   = 3'b011;
    localparam logic [2:0] S_WB    = 3'b100;
    localparam logic [2:0] S_HALT  = 3'b101;
    localparam logic [2:0] S_FAULT = 3'b110;

    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011;

    localparam logic [2:0] C_ALU  = 3'd0;
    localparam logic [2:0] C_LW   = 3'd1;
    localparam logic [2:0] C_SW   = 3'd2;
    localparam logic [2:0] C_CT   = 3'd3;
    localparam logic [2:0] C_NOP  = 3'd4;
    localparam logic [2:0] C_HALT = 3'd5;
    localparam logic [2:0] C_ILL  = 3'd6;

    function automatic logic [2:0] f_class(input logic [5:0] op);
        case (op)
            6'b000000, 6'b001000, 6'b001100,
            6'b001101, 6'b001110:             f_class = C_ALU;
            OP_LW:                            f_class = C_LW;
            OP_SW:                            f_class = C_SW;
            6'b011000, 6'b001001, 6'b010001,
            6'b000011, 6'b000111:             f_class = C_CT;
            6'b000001:                        f_class = C_NOP;
            6'b000010:                        f_class = C_HALT;
            default:                          f_class = C_ILL;
        endcase
    endfunction

    logic [2:0]       r_state;
    logic [5:0]       r_op;
    logic [WW-1:0]    r_wait;
    logic [RET_W-1:0] r_retired;

    logic [2:0]       w_next;
    logic             w_timeout;
    logic             w_write_pc;
    logic             w_halt_entry;
    logic             w_mem_phase;

    assign w_mem_phase = (r_state == S_IF) || (r_state == S_MEM);

    // Fault on the wait cycle that would bring the counter to WAIT_MAX;
    // a same-cycle mem_ready wins.
    assign w_timeout = (WAIT_MAX != 0) && !i_mem_ready && (r_wait == WAIT_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IF: begin
                if (i_mem_ready)    w_next = S_ID;
                else if (w_timeout) w_next = S_FAULT;
            end
            S_ID: begin
                case (f_class(i_opcode))
                    C_NOP:   w_next = S_IF;
                    C_HALT:  w_next = S_HALT;
                    C_ILL:   w_next = S_FAULT;
                    default: w_next = S_EX;
                endcase
            end
            S_EX: begin
                case (f_class(r_op))
                    C_ALU:       w_next = S_WB;
                    C_LW, C_SW:  w_next = S_MEM;
                    C_CT:        w_next = S_IF;
                    default:     w_next = S_FAULT;
                endcase
            end
            S_MEM: begin
                if (i_mem_ready)    w_next = (r_op == OP_LW) ? S_WB : S_IF;
                else if (w_timeout) w_next = S_FAULT;
            end
            S_WB:    w_next = S_IF;
            S_HALT:  if (i_resume) w_next = S_IF;
            S_FAULT: w_next = S_FAULT;
            default: w_next = S_FAULT;
        endcase
    end

    // Every path ends by returning to IF; a stall in IF is not an end.
    assign w_write_pc   = (r_state != S_IF) && (w_next == S_IF);
    assign w_halt_entry = (r_state == S_ID) && (w_next == S_HALT);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IF;
            r_op      <= '0;
            r_wait    <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_ID) r_op <= i_opcode;
            // Outside IF/MEM the counter sits at 0, so entry starts clean.
            if (w_mem_phase && !i_mem_ready) r_wait <= r_wait + WW'(1);
            else                             r_wait <= '0;
            if (w_write_pc || w_halt_entry)  r_retired <= r_retired + RET_W'(1);
        end
    end

    always_comb begin
        o_stage    = 3'b000;
        o_inst_req = 1'b0;
        o_ir_load  = 1'b0;
        o_data_req = 1'b0;
        o_data_we  = 1'b0;
        o_rf_we    = 1'b0;
        o_write_pc = 1'b0;
        o_halted   = 1'b0;
        o_fault    = 1'b0;
        o_retired  = '0;
        if (!i_rst) begin
            o_stage    = r_state;
            o_inst_req = (r_state == S_IF);
            o_ir_load  = (r_state == S_IF) && i_mem_ready;
            o_data_req = (r_state == S_MEM);
            o_data_we  = (r_state == S_MEM) && (r_op == OP_SW);
            o_rf_we    = (r_state == S_WB);
            o_write_pc = w_write_pc;
            o_halted   = (r_state == S_HALT);
            o_fault    = (r_state == S_FAULT);
            o_retired  = r_retired;
        end
    end

endmodule

// File: tb/tb_stage_sequencer.sv
module tb_stage_sequencer;

    localparam logic [5:0] ALU  = 6'b000000;
    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] JR   = 6'b011000;
    localparam logic [5:0] NOP  = 6'b000001;
    localparam logic [5:0] HALT = 6'b000010;
    localparam logic [5:0] ILL  = 6'b111111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, mem_ready, resume;
    logic [5:0]  opcode;
    logic [2:0]  o_stage;
    logic        o_inst_req, o_ir_load, o_data_req, o_data_we;
    logic        o_rf_we, o_write_pc, o_halted, o_fault;
    logic [15:0] o_retired;

    stage_sequencer #(.WAIT_MAX(15), .RET_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_opcode(opcode), .i_mem_ready(mem_ready),
        .i_resume(resume), .o_stage(o_stage), .o_inst_req(o_inst_req),
        .o_ir_load(o_ir_load), .o_data_req(o_data_req), .o_data_we(o_data_we),
        .o_rf_we(o_rf_we), .o_write_pc(o_write_pc), .o_halted(o_halted),
        .o_fault(o_fault), .o_retired(o_retired)
    );

    // Narrow-counter instance running back-to-back nops for the wrap check.
    logic        rst_w, mr_w, res_w;
    logic [5:0]  op_w;
    logic [2:0]  w_stage;
    logic        w_inst_req, w_ir_load, w_data_req, w_data_we;
    logic        w_rf_we, w_write_pc, w_halted, w_fault;
    logic [3:0]  w_retired;

    stage_sequencer #(.WAIT_MAX(15), .RET_W(4)) u_wrap (
        .i_clk(clk), .i_rst(rst_w), .i_opcode(op_w), .i_mem_ready(mr_w),
        .i_resume(res_w), .o_stage(w_stage), .o_inst_req(w_inst_req),
        .o_ir_load(w_ir_load), .o_data_req(w_data_req), .o_data_we(w_data_we),
        .o_rf_we(w_rf_we), .o_write_pc(w_write_pc), .o_halted(w_halted),
        .o_fault(w_fault), .o_retired(w_retired)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] outs();
        return {o_stage, o_inst_req, o_ir_load, o_data_req, o_data_we,
                o_rf_we, o_write_pc, o_halted, o_fault};
    endfunction

    // flags = {inst_req, ir_load, data_req, data_we, rf_we, write_pc, halted, fault}
    task automatic step(input string tag, input logic mr, input logic rs,
                        input logic [5:0] op, input logic [2:0] es, input logic [7:0] ef);
        mem_ready = mr;
        resume    = rs;
        opcode    = op;
        #1;
        chk(tag, {21'b0, outs()}, {21'b0, es, ef});
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        chk(tag, {21'b0, outs()}, 32'h0);
        chk({tag, "_ret"}, {16'b0, o_retired}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b1; resume = 1'b0; opcode = ALU;
        rst_w = 1'b1; mr_w = 1'b1; res_w = 1'b0; op_w = NOP;
        #1;
        chk("rst_outs", {21'b0, outs()}, 32'h0);
        chk("rst_ret", {16'b0, o_retired}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ALU: IF ID EX WB
        step("alu_if", 1, 0, ALU, 3'd0, 8'hC0);
        step("alu_id", 1, 0, ALU, 3'd1, 8'h00);
        step("alu_ex", 1, 0, ALU, 3'd2, 8'h00);
        step("alu_wb", 1, 0, ALU, 3'd4, 8'h0C);
        chk("alu_ret", {16'b0, o_retired}, 32'd1);

        // lw with 2 IF waits and 3 MEM waits: 10 cycles
        step("lw_if_w", 0, 0, LW, 3'd0, 8'h80);
        step("lw_if_w", 0, 0, LW, 3'd0, 8'h80);
        step("lw_if",   1, 0, LW, 3'd0, 8'hC0);
        step("lw_id",   1, 0, LW, 3'd1, 8'h00);
        step("lw_ex",   1, 0, LW, 3'd2, 8'h00);
        step("lw_mem_w", 0, 0, LW, 3'd3, 8'h20);
        step("lw_mem_w", 0, 0, LW, 3'd3, 8'h20);
        step("lw_mem_w", 0, 0, LW, 3'd3, 8'h20);
        step("lw_mem",  1, 0, LW, 3'd3, 8'h20);
        step("lw_wb",   1, 0, LW, 3'd4, 8'h0C);
        chk("lw_ret", {16'b0, o_retired}, 32'd2);

        // sw (opcode changed after ID must not matter), then jr
        step("sw_if",  1, 0, SW, 3'd0, 8'hC0);
        step("sw_id",  1, 0, SW, 3'd1, 8'h00);
        step("sw_ex",  1, 0, JR, 3'd2, 8'h00);
        step("sw_mem", 1, 0, JR, 3'd3, 8'h34);
        chk("sw_ret", {16'b0, o_retired}, 32'd3);
        step("jr_if",  1, 1, JR, 3'd0, 8'hC0);
        step("jr_id",  1, 0, JR, 3'd1, 8'h00);
        step("jr_ex",  1, 0, JR, 3'd2, 8'h04);
        chk("jr_ret", {16'b0, o_retired}, 32'd4);

        // halt, hold 5 cycles, resume
        step("halt_if", 1, 0, HALT, 3'd0, 8'hC0);
        step("halt_id", 1, 0, HALT, 3'd1, 8'h00);
        chk("halt_ret", {16'b0, o_retired}, 32'd5);
        for (int i = 0; i < 5; i++) step("halt_hold", 1, 0, HALT, 3'd5, 8'h02);
        step("halt_resume", 0, 1, HALT, 3'd5, 8'h06);
        chk("resume_ret", {16'b0, o_retired}, 32'd6);

        // nop
        step("nop_if", 1, 0, NOP, 3'd0, 8'hC0);
        step("nop_id", 1, 0, NOP, 3'd1, 8'h04);
        chk("nop_ret", {16'b0, o_retired}, 32'd7);

        // illegal opcode -> sticky FAULT
        step("ill_if", 1, 0, ILL, 3'd0, 8'hC0);
        step("ill_id", 1, 0, ILL, 3'd1, 8'h00);
        for (int i = 0; i < 3; i++) step("ill_fault", 1, 1, ALU, 3'd6, 8'h01);
        chk("ill_ret", {16'b0, o_retired}, 32'd7);
        do_reset("rst_ill");

        // IF timeout: 15 wait cycles then FAULT
        for (int i = 0; i < 15; i++) step("to_if_w", 0, 0, NOP, 3'd0, 8'h80);
        step("to_fault", 1, 1, NOP, 3'd6, 8'h01);
        step("to_fault_stk", 1, 0, NOP, 3'd6, 8'h01);
        do_reset("rst_to");

        // mem_ready on the would-be timeout cycle counts as success
        for (int i = 0; i < 14; i++) step("edge_if_w", 0, 0, NOP, 3'd0, 8'h80);
        step("edge_if",  1, 0, NOP, 3'd0, 8'hC0);
        step("edge_id",  1, 0, NOP, 3'd1, 8'h04);
        chk("edge_ret", {16'b0, o_retired}, 32'd1);

        // reset during a MEM wait aborts without rf_we/write_pc
        step("ab_if",    1, 0, LW, 3'd0, 8'hC0);
        step("ab_id",    1, 0, LW, 3'd1, 8'h00);
        step("ab_ex",    1, 0, LW, 3'd2, 8'h00);
        step("ab_mem_w", 0, 0, LW, 3'd3, 8'h20);
        mem_ready = 1'b0;
        do_reset("ab_rst");
        step("ab_after", 0, 0, LW, 3'd0, 8'h80);

        // wrap: 15 nops fill a 4-bit counter, the 16th wraps it to 0
        rst_w = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("wrap_full", {28'b0, w_retired}, 32'd15);
        chk("wrap_if", {29'b0, w_stage}, 32'd0);
        @(posedge clk); #1;
        chk("wrap_id", {21'b0, w_stage, w_inst_req, w_ir_load, w_data_req, w_data_we,
                        w_rf_we, w_write_pc, w_halted, w_fault}, {21'b0, 3'd1, 8'h04});
        chk("wrap_pre", {28'b0, w_retired}, 32'd15);
        @(posedge clk); #1;
        chk("wrap_zero", {28'b0, w_retired}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
